// File: rtl/flash_rom_frontend_pkg.sv
// Shared types and widths for the flash-backed ROM front end.
// Holds the word-address width and the flash request FSM state encoding.
package flash_rom_frontend_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/flash_rom_frontend_if.sv
// Bus bundles for the ROM requester side and the flash controller side.
// rom: single-cycle rom_req strobe, answered by exactly one single-cycle rom_ack.
interface rom_bus_if;
  import flash_rom_frontend_pkg::*;

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              rom_ack;

  modport master (output rom_req, rom_addr, input  rom_dout, rom_ack);
  modport slave  (input  rom_req, rom_addr, output rom_dout, rom_ack);
endinterface

// flash: flash_cs is edge-detected; flash_addr holds until flash_busy falls, then flash_dout is valid.
interface flash_bus_if;
  import flash_rom_frontend_pkg::*;

  logic              flash_ready;
  logic              flash_busy;
  logic              flash_cs;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_dout;

  modport master (output flash_cs, flash_addr, input  flash_ready, flash_busy, flash_dout);
  modport slave  (input  flash_cs, flash_addr, output flash_ready, flash_busy, flash_dout);
endinterface

// File: rtl/flash_rom_frontend.sv
// One-entry read buffer in front of a slow flash controller, with optional
// sequential next-word prefetch and demand promotion of an in-flight prefetch.
module flash_rom_frontend
  import flash_rom_frontend_pkg::*;
#(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  rom_bus_if.slave   rom,
  flash_bus_if.master flash,
  output fsm_state_t o_dbg_state
);

  fsm_state_t        r_state, w_next;
  logic              r_fetch_is_demand;
  logic [ADDR_W-1:0] r_flash_addr;
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_dem_valid;   // a demand is outstanding (pending or in flight)
  logic              r_dem_issued;
  logic [ADDR_W-1:0] r_dem_addr;
  logic              r_pf_pend;
  logic [ADDR_W-1:0] r_pf_addr;

  logic w_ready, w_busy, w_dem_pend, w_start, w_done, w_done_dem;
  logic w_accept, w_hit, w_promote, w_miss;

  assign w_ready    = flash.flash_ready;
  assign w_busy     = flash.flash_busy;
  assign w_dem_pend = r_dem_valid & ~r_dem_issued;
  assign w_start    = (r_state == IDLE) & w_ready & ~w_busy & (w_dem_pend | r_pf_pend);
  assign w_done     = (r_state == WAIT_DONE) & w_ready & ~w_busy;

  // Requests arriving while a demand is outstanding are dropped on the floor.
  assign w_accept   = rom.rom_req & ~r_dem_valid;
  assign w_hit      = w_accept & r_buf_valid & w_ready & (rom.rom_addr == r_buf_addr);
  assign w_promote  = w_accept & ~w_hit & w_ready & (r_state != IDLE) & ~r_fetch_is_demand
                    & (rom.rom_addr == r_flash_addr);
  assign w_miss     = w_accept & ~w_hit & ~w_promote;
  assign w_done_dem = w_done & (r_fetch_is_demand | w_promote);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_start) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (w_busy) w_next = WAIT_DONE;
      WAIT_DONE: if (!w_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (!w_ready) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_is_demand <= 1'b0;
      r_flash_addr      <= '0;
      r_buf_valid       <= 1'b0;
      r_buf_addr        <= '0;
      r_buf_data        <= '0;
      r_dout            <= '0;
      r_ack             <= 1'b0;
      r_dem_valid       <= 1'b0;
      r_dem_issued      <= 1'b0;
      r_dem_addr        <= '0;
      r_pf_pend         <= 1'b0;
      r_pf_addr         <= '0;
    end else begin
      r_ack <= 1'b0;

      if (w_start) begin
        r_flash_addr      <= w_dem_pend ? r_dem_addr : r_pf_addr;
        r_fetch_is_demand <= w_dem_pend;
        if (w_dem_pend) r_dem_issued <= 1'b1;
        else            r_pf_pend    <= 1'b0;
      end

      if (w_done) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= r_flash_addr;
        r_buf_data  <= flash.flash_dout;
        if (w_done_dem) begin
          r_ack       <= 1'b1;
          r_dout      <= flash.flash_dout;
          r_dem_valid <= 1'b0;
          if (PREFETCH_EN) begin
            r_pf_pend <= 1'b1;
            r_pf_addr <= r_flash_addr + ADDR_W'(1);
          end
        end else if (r_pf_pend && (r_pf_addr == r_flash_addr)) begin
          r_pf_pend <= 1'b0;
        end
      end

      if (w_hit) begin
        r_ack  <= 1'b1;
        r_dout <= r_buf_data;
        if (PREFETCH_EN) begin
          r_pf_pend <= 1'b1;
          r_pf_addr <= rom.rom_addr + ADDR_W'(1);
        end
      end

      // Promotion in the completion cycle is already handled as a demand completion above.
      if (w_promote && !w_done) begin
        r_fetch_is_demand <= 1'b1;
        r_dem_valid       <= 1'b1;
        r_dem_issued      <= 1'b1;
        r_dem_addr        <= rom.rom_addr;
        r_pf_pend         <= 1'b0;
      end

      if (w_miss) begin
        r_dem_valid  <= 1'b1;
        r_dem_issued <= 1'b0;
        r_dem_addr   <= rom.rom_addr;
        r_pf_pend    <= 1'b0;
      end

      // Losing the controller invalidates the buffer; an in-flight demand goes back to pending.
      if (!w_ready) begin
        r_buf_valid <= 1'b0;
        if ((r_state != IDLE) && r_fetch_is_demand) r_dem_issued <= 1'b0;
      end
    end
  end

  assign rom.rom_dout     = r_dout;
  assign rom.rom_ack      = r_ack;
  assign flash.flash_cs   = (r_state == ISSUE);
  assign flash.flash_addr = r_flash_addr;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_flash_rom_frontend.sv
// Bench for flash_rom_frontend: flash model, directed scenarios, randomized
// traffic against a word-level reference, scoreboard and one summary line.
module tb_flash_rom_frontend;
  import flash_rom_frontend_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rom_bus_if   rom();
  flash_bus_if flash();
  fsm_state_t  dbg_state;

  logic              tb_req   = 1'b0;
  logic [21:0]       tb_addr  = '0;
  logic              tb_ready = 1'b0;
  logic              fm_busy  = 1'b0;
  logic [15:0]       fm_dout  = '0;

  assign rom.rom_req       = tb_req;
  assign rom.rom_addr      = tb_addr;
  assign flash.flash_ready = tb_ready;
  assign flash.flash_busy  = fm_busy;
  assign flash.flash_dout  = fm_dout;

  flash_rom_frontend #(.PREFETCH_EN(1'b1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rom         (rom),
    .flash       (flash),
    .o_dbg_state (dbg_state)
  );

  // ---------------- flash controller model ----------------
  // Busy for 24 cycles after a cs rising edge; data = addr[15:0] ^ A5A5. Not reset by resetn.
  logic        fm_prev_cs = 1'b0;
  int          fm_cnt     = 0;
  logic [21:0] fm_addr    = '0;

  always @(posedge clk) begin
    fm_prev_cs <= flash.flash_cs;
    if (flash.flash_cs && !fm_prev_cs && !fm_busy) begin
      fm_busy <= 1'b1;
      fm_cnt  <= 23;
      fm_addr <= flash.flash_addr;
    end else if (fm_busy) begin
      if (fm_cnt == 0) begin
        fm_busy <= 1'b0;
        fm_dout <= fm_addr[15:0] ^ 16'hA5A5;
      end else begin
        fm_cnt <= fm_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [21:0] cs_q[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          ack_count = 0;
  logic        cs_prev   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_true(input string name, input bit cond, input logic [31:0] info);
    n_checks++;
    if (cond) n_pass++;
    else $display("FAIL %s: condition false (value 0x%0h)", name, info);
  endtask

  always @(negedge clk) begin
    if (resetn && rom.rom_ack) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        chk_true("unexpected_ack", 1'b0, 32'(rom.rom_dout));
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("ack_data", 32'(rom.rom_dout), 32'(e));
      end
    end
    if (resetn && flash.flash_cs) begin
      chk_true("cs_back_to_back", !cs_prev, 32'(flash.flash_addr));
      chk_true("cs_while_busy", !flash.flash_busy, 32'(flash.flash_addr));
      cs_q.push_back(flash.flash_addr);
    end
    cs_prev = flash.flash_cs;
  end

  // ---------------- reference model ----------------
  // After the bus has been quiet, the buffer always holds last served word + 1.
  logic [21:0] m_next  = '0;
  bit          m_valid = 1'b0;

  // ---------------- driver ----------------
  task automatic do_req(input logic [21:0] a, output int lat);
    @(posedge clk); #1;
    tb_req  = 1'b1;
    tb_addr = a;
    exp_q.push_back(a[15:0] ^ 16'hA5A5);
    @(posedge clk); #1;
    tb_req  = 1'b0;
    tb_addr = 22'($urandom);
    lat = 1;
    while (!rom.rom_ack && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rom.rom_ack) begin
      chk_true("ack_timeout", 1'b0, 32'(a));
      exp_q.delete();
    end else begin
      m_next  = a + 22'd1;
      m_valid = 1'b1;
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    int          w;
    int          acks_before;
    logic [21:0] a;
    bit          pred_hit;
    bit          was_quiet;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_ack", 32'(rom.rom_ack), 32'd0);
    chk("rst_rom_dout", 32'(rom.rom_dout), 32'd0);
    chk("rst_flash_cs", 32'(flash.flash_cs), 32'd0);
    chk("rst_flash_addr", 32'(flash.flash_addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    resetn   = 1'b1;
    tb_ready = 1'b1;
    quiet(5);

    // Cold miss
    cs_q.delete();
    do_req(22'h000100, lat);
    chk_true("cold_miss_latency", lat >= 24, 32'(lat));
    chk("cold_cs_count", 32'(cs_q.size()), 32'd1);
    if (cs_q.size() >= 1) chk("cold_cs_addr", 32'(cs_q[0]), 32'h000100);
    quiet(40);
    chk("cold_prefetch_count", 32'(cs_q.size()), 32'd2);
    if (cs_q.size() >= 2) chk("cold_prefetch_addr", 32'(cs_q[1]), 32'h000101);

    // Sequential hit, then conflicting request during the 0x102 prefetch
    cs_q.delete();
    do_req(22'h000101, lat);
    chk("seq_hit_latency", 32'(lat), 32'd1);
    quiet(5);
    do_req(22'h000200, lat);
    quiet(40);
    chk("conflict_cs_count", 32'(cs_q.size()), 32'd3);
    if (cs_q.size() >= 3) begin
      chk("conflict_cs0", 32'(cs_q[0]), 32'h000102);
      chk("conflict_cs1", 32'(cs_q[1]), 32'h000200);
      chk("conflict_cs2", 32'(cs_q[2]), 32'h000201);
    end
    do_req(22'h000201, lat);
    chk("conflict_buf_hit", 32'(lat), 32'd1);
    quiet(40);

    // Address wrap
    cs_q.delete();
    do_req(22'h3FFFFF, lat);
    quiet(40);
    chk("wrap_cs_count", 32'(cs_q.size()), 32'd2);
    if (cs_q.size() >= 2) chk("wrap_prefetch_addr", 32'(cs_q[1]), 32'h000000);
    cs_q.delete();
    do_req(22'h000000, lat);
    chk("wrap_hit_latency", 32'(lat), 32'd1);

    // Promotion of the in-flight 0x000001 prefetch
    quiet(5);
    do_req(22'h000001, lat);
    chk_true("promote_latency", lat > 1 && lat < 40, 32'(lat));
    quiet(40);
    chk("promote_cs_count", 32'(cs_q.size()), 32'd2);
    if (cs_q.size() >= 2) begin
      chk("promote_cs0", 32'(cs_q[0]), 32'h000001);
      chk("promote_cs1", 32'(cs_q[1]), 32'h000002);
    end

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      was_quiet = ($urandom_range(0, 1) == 1);
      if (was_quiet) quiet(60);
      else           quiet($urandom_range(0, 35));
      if ($urandom_range(0, 3) < 2 && m_valid) a = m_next;
      else                                     a = 22'($urandom);
      pred_hit = was_quiet && m_valid && (a == m_next);
      do_req(a, lat);
      if (pred_hit)       chk("rand_hit_latency", 32'(lat), 32'd1);
      else if (was_quiet) chk_true("rand_miss_latency", lat >= 24, 32'(lat));
    end
    quiet(60);

    // Reset in the middle of a fetch, then controller not ready for 20 cycles
    a = m_next ^ 22'h155555;
    @(posedge clk); #1;
    tb_req  = 1'b1;
    tb_addr = a;
    @(posedge clk); #1;
    tb_req  = 1'b0;
    w = 0;
    while (dbg_state != WAIT_DONE && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk_true("reach_wait_done", dbg_state == WAIT_DONE, 32'(w));
    repeat (3) @(posedge clk);
    #1;
    acks_before = ack_count;
    resetn   = 1'b0;
    tb_ready = 1'b0;
    #1;
    chk("mid_rst_rom_ack", 32'(rom.rom_ack), 32'd0);
    chk("mid_rst_rom_dout", 32'(rom.rom_dout), 32'd0);
    chk("mid_rst_flash_cs", 32'(flash.flash_cs), 32'd0);
    chk("mid_rst_flash_addr", 32'(flash.flash_addr), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1 tb_ready = 1'b1;
    quiet(10);
    chk("no_ack_for_aborted", 32'(ack_count), 32'(acks_before));
    m_valid = 1'b0;
    do_req(m_next, lat);
    chk_true("post_reset_miss_latency", lat >= 24, 32'(lat));
    quiet(60);

    // Demand issued while the controller is not ready must wait, not be lost
    tb_ready = 1'b0;
    @(posedge clk); #1;
    fork
      do_req(22'h02AAAA, lat);
      begin
        repeat (15) @(posedge clk);
        #1 tb_ready = 1'b1;
      end
    join
    chk_true("not_ready_wait_latency", lat >= 30, 32'(lat));
    quiet(40);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
